// File: rtl/calc_sequencer.sv
// Key-driven sequencer for the add/subtract calculator: captures A, B and op,
// registers the external adder result, and drives the HEX/symbol enables with field blink.
module calc_sequencer #(
    parameter int WIDTH        = 4,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic [WIDTH-1:0] data,
    input  logic             s,
    input  logic [WIDTH-1:0] sum,
    input  logic             adder_cout,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             s_out,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic [1:0]       state,
    output logic             show_a,
    output logic             show_b,
    output logic             show_res,
    output logic             done
);

    // state   | meaning
    // ENTER_A | a_out follows switches; press latches A
    // ENTER_B | b_out/s_out follow switches; press latches B and op
    // COMPUTE | single cycle, adder settles on frozen operands
    // SHOW    | result displayed; press starts a new calculation
    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        COMPUTE = 2'b10,
        SHOW    = 2'b11
    } state_t;

    localparam int CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    state_t           state_q;
    state_t           state_nxt;
    logic             enter_prev;
    logic             press;
    logic [CNT_W-1:0] blink_cnt;
    logic             phase;

    assign press = enter & ~enter_prev;
    assign state = state_q;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ENTER_A: if (press) state_nxt = ENTER_B;
            ENTER_B: if (press) state_nxt = COMPUTE;
            COMPUTE: state_nxt = SHOW;
            SHOW:    if (press) state_nxt = ENTER_A;
            default: state_nxt = ENTER_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ENTER_A;
            a_out      <= '0;
            b_out      <= '0;
            s_out      <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            done       <= 1'b0;
            blink_cnt  <= '0;
            phase      <= 1'b1;
            enter_prev <= 1'b1;
        end else begin
            enter_prev <= enter;
            state_q    <= state_nxt;
            done       <= (state_q == COMPUTE);
            case (state_q)
                ENTER_A: a_out <= data;
                ENTER_B: begin
                    b_out <= data;
                    s_out <= s;
                end
                COMPUTE: begin
                    result    <= sum;
                    carry_out <= adder_cout;
                end
                default: ;
            endcase
            // A new field always starts in the visible half of the blink.
            if (state_nxt != state_q) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (blink_cnt == CNT_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        show_a   = 1'b1;
        show_b   = 1'b1;
        show_res = 1'b0;
        case (state_q)
            ENTER_A: begin
                show_a = phase;
                show_b = 1'b0;
            end
            ENTER_B: show_b = phase;
            SHOW:    show_res = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios with literal expectations plus
// random key/switch traffic, all checked every cycle against a behavioural model.
module tb_calc_sequencer;
    localparam int W  = 4;
    localparam int BL = 4;

    logic         clk = 1'b0;
    logic         reset, enter, s, adder_cout;
    logic [W-1:0] data, sum;
    logic [W-1:0] a_out, b_out, result;
    logic         s_out, carry_out, show_a, show_b, show_res, done;
    logic [1:0]   state;
    logic [W:0]   full;

    int n_checks = 0;
    int n_fail   = 0;

    calc_sequencer #(.WIDTH(W), .BLINK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .enter(enter), .data(data), .s(s),
        .sum(sum), .adder_cout(adder_cout), .a_out(a_out), .b_out(b_out),
        .s_out(s_out), .result(result), .carry_out(carry_out), .state(state),
        .show_a(show_a), .show_b(show_b), .show_res(show_res), .done(done)
    );

    always #5 clk = ~clk;

    // External ripple adder/subtractor as the lab datapath builds it.
    assign full = s_out ? ({1'b0, a_out} + {1'b0, ~b_out} + (W+1)'(1))
                        : ({1'b0, a_out} + {1'b0, b_out});
    assign sum        = full[W-1:0];
    assign adder_cout = full[W];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: state as a step number 0..3 plus cycles spent in it.
    int           m_st, m_cis;
    logic [W-1:0] m_a, m_b, m_res;
    logic         m_s, m_c, m_prev;
    bit           mvalid = 0;

    always @(posedge clk) begin
        bit press;
        int ns, t;
        press  = enter && !m_prev;
        m_prev = enter;
        if (reset) begin
            m_st = 0; m_cis = 0; m_a = 0; m_b = 0; m_res = 0;
            m_s = 0; m_c = 0; m_prev = 1; mvalid = 1;
        end else if (mvalid) begin
            ns = m_st;
            case (m_st)
                0: begin m_a = data; if (press) ns = 1; end
                1: begin m_b = data; m_s = s; if (press) ns = 2; end
                2: begin
                    if (m_s) begin
                        t   = int'(m_a) - int'(m_b);
                        m_c = (m_a >= m_b);
                    end else begin
                        t   = int'(m_a) + int'(m_b);
                        m_c = (t >= (1 << W));
                    end
                    m_res = W'((t + (1 << W)) % (1 << W));
                    ns = 3;
                end
                default: if (press) ns = 0;
            endcase
            m_cis = (ns == m_st) ? m_cis + 1 : 0;
            m_st  = ns;
        end
    end

    always @(negedge clk) begin
        bit ph;
        if (mvalid) begin
            ph = ((m_cis / BL) % 2) == 0;
            chk("state", int'(state), m_st);
            chk("a_out", int'(a_out), int'(m_a));
            chk("b_out", int'(b_out), int'(m_b));
            chk("s_out", int'(s_out), int'(m_s));
            chk("result", int'(result), int'(m_res));
            chk("carry_out", int'(carry_out), int'(m_c));
            chk("done", int'(done), int'(m_st == 3 && m_cis == 0));
            chk("show_a", int'(show_a), (m_st == 0) ? int'(ph) : 1);
            chk("show_b", int'(show_b), (m_st == 0) ? 0 : (m_st == 1) ? int'(ph) : 1);
            chk("show_res", int'(show_res), int'(m_st == 3));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key();
        enter = 1'b1;
        step(1);
        enter = 1'b0;
    endtask

    task automatic op(input int a, input int b, input int sv, input int er, input int ec);
        data = W'(a);
        step(1);
        press_key();
        data = W'(b);
        s    = sv[0];
        step(1);
        press_key();
        chk("op_compute", int'(state), 2);
        step(1);
        chk("op_show", int'(state), 3);
        chk("op_result", int'(result), er);
        chk("op_carry", int'(carry_out), ec);
        chk("op_done", int'(done), 1);
        chk("op_show_res", int'(show_res), 1);
        step(1);
        chk("op_done_drop", int'(done), 0);
        press_key();
        chk("op_back_a", int'(state), 0);
    endtask

    initial begin
        int pat_a[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        int pat_b[5] = '{1, 1, 1, 1, 0};
        reset = 1'b1; enter = 1'b1; data = '0; s = 1'b0;
        step(3);
        reset = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_result", int'(result), 0);
        step(3);
        chk("held_no_press", int'(state), 0);
        enter = 1'b0;
        step(1);
        press_key();
        chk("first_press", int'(state), 1);

        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("blink_a", int'(show_a), pat_a[i]);
            step(1);
        end

        op(5, 3, 0, 8, 0);
        op(9, 8, 0, 1, 1);
        op(5, 3, 1, 2, 1);
        op(3, 5, 1, 14, 0);

        data = 4'd2; step(1);
        chk("live_a2", int'(a_out), 2);
        data = 4'd7; step(1);
        chk("live_a7", int'(a_out), 7);
        press_key();
        data = 4'd4;
        for (int i = 0; i < 5; i++) begin
            chk("blink_b", int'(show_b), pat_b[i]);
            step(1);
        end
        chk("frozen_a", int'(a_out), 7);
        chk("live_b", int'(b_out), 4);
        s = 1'b1;
        enter = 1'b1;
        step(2);
        chk("held_through_compute", int'(state), 3);
        enter = 1'b0;
        data = 4'd15; s = 1'b0;
        step(2);
        chk("show_hold_a", int'(a_out), 7);
        chk("show_hold_b", int'(b_out), 4);
        chk("show_hold_s", int'(s_out), 1);
        chk("show_result", int'(result), 3);
        chk("show_state", int'(state), 3);
        press_key();

        data = 4'd6; step(1);
        press_key();
        data = 4'd2; step(1);
        press_key();
        chk("pre_reset_compute", int'(state), 2);
        reset = 1'b1; enter = 1'b1;
        step(1);
        chk("rst_compute_state", int'(state), 0);
        chk("rst_compute_result", int'(result), 0);
        chk("rst_compute_a", int'(a_out), 0);
        reset = 1'b0; enter = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            enter = ($urandom_range(0, 2) == 0);
            data  = W'($urandom);
            s     = 1'($urandom);
            step(1);
        end
        reset = 1'b0; enter = 1'b0;
        step(2);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Control FSM for the lab's add/subtract calculator datapath. It captures operand A, operand B and the operation select from switches, one key press per step. It presents the latched operands to the external ripple adder/subtractor and registers the adder's sum and carry. Its registered outputs drive the HEX digit encoders and the symbol logic (op/eq/prefix), plus per-field blink enables that show the user which field is being entered.

Parameters:
WIDTH, 4, operand/result width in bits
BLINK_CYCLES, 25_000_000, clock cycles per blink half-period; minimum 2; benches use 4

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high
enter  input  1  key level, active-high; already debounced and synchronized upstream
data  input  WIDTH  operand switches
s  input  1  operation select: 0 = add, 1 = subtract
sum  input  WIDTH  adder datapath result
adder_cout  input  1  adder datapath carry-out
a_out  output  WIDTH  operand A to adder and HEX encoder
b_out  output  WIDTH  operand B to adder and HEX encoder
s_out  output  1  operation to adder and symbol logic
result  output  WIDTH  registered sum
carry_out  output  1  registered carry; feeds symbol logic carryOut
state  output  2  current FSM state
show_a  output  1  HEX enable for A field
show_b  output  1  HEX enable for B field
show_res  output  1  HEX enable for result field and "=" symbol
done  output  1  one-cycle pulse, high in the first SHOW cycle

Behaviour:
- Reset (synchronous, highest priority over all events): state=ENTER_A; a_out, b_out, result = 0; s_out, carry_out, done = 0; blink counter = 0; blink phase = 1; enter_prev = 1.
- enter_prev resets to 1, so a key held through reset gives no press until it is released and pressed again.
- Press: press = enter & ~enter_prev; enter_prev <= enter every cycle. Exactly one press per rising level.
- The state change happens at the same clock edge where enter is first sampled high.
- States (encoding in brackets):
  - ENTER_A (00): a_out <= data every cycle. On press: a_out <= data and the value freezes; go to ENTER_B.
  - ENTER_B (01): b_out <= data and s_out <= s every cycle. On press: both freeze; go to COMPUTE.
  - COMPUTE (10): lasts exactly 1 cycle. result <= sum and carry_out <= adder_cout at the end of that cycle; go to SHOW. Presses here are discarded, but enter_prev still updates.
  - SHOW (11): all registers hold. done = 1 in the first SHOW cycle only. On press: go to ENTER_A. result and carry_out are retained until the next COMPUTE.
- The adder is external and combinational. a_out, b_out and s_out are stable throughout COMPUTE, so the adder has one full cycle to settle.
- Subtract convention, as implemented by the datapath: sum = a + ~b + 1 mod 2^WIDTH. carry=1 means no borrow.
- Blink: the counter runs 0..BLINK_CYCLES-1. On wrap it returns to 0 and phase toggles. Any state change clears the counter to 0 and sets phase to 1, so a new field starts visible.
- Display enables (combinational from state and phase):
  - ENTER_A: show_a=phase, show_b=0, show_res=0.
  - ENTER_B: show_a=1, show_b=phase, show_res=0.
  - COMPUTE: show_a=1, show_b=1, show_res=0.
  - SHOW: show_a=1, show_b=1, show_res=1.
- No unreachable-state lockup: any illegal state value returns to ENTER_A on the next edge.
- Reset mid-operation, including during COMPUTE: all outputs return to reset values on that edge, and any press in the same cycle is ignored.

Test Plan:
- Reset with enter held high, then release and press once. Expected: state stays 00 until the new press, then 01; all outputs 0 after reset.
- Add, no carry: A=5, press, B=3, s=0, press. Expected: state 01→10→11; result=8, carry_out=0; done high for exactly 1 cycle; show_res=1.
- Add with carry: A=9, B=8, s=0. Expected: result=1, carry_out=1.
- Subtract both signs: A=5, B=3, s=1 gives result=2, carry_out=1. Then press (state 00), A=3, B=5, s=1 gives result=0xE, carry_out=0.
- Live vs frozen: in ENTER_A, change data 2→7 and confirm a_out tracks it. Press, then change data to 4: a_out stays 7 and b_out tracks 4. In SHOW, change data and s: no output changes.
- Blink and timing (BLINK_CYCLES=4): in ENTER_A, show_a reads 1,1,1,1,0,0,0,0,1… After a press, show_b restarts at 1 for 4 cycles. A press in COMPUTE is ignored. Reset asserted during COMPUTE gives state=00, result=0 on the next edge.
